prog_sequencer: RTL and testbench

//  Parametrised next-generation program sequencer for the 9-bit core: replaces fixed PC/jump-LUT pair.

---
 rtl/prog_seq_pkg.sv | 36 +++
 rtl/prog_seq_if.sv | 29 ++
 rtl/seq_ret_stack.sv | 49 ++++
 rtl/prog_sequencer.sv | 119 +++++++++++
 tb/tb_prog_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and width helpers for the program sequencer and its return stack.
package prog_seq_pkg;

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        FAULT
    } seq_state_e;

    typedef enum logic [2:0] {
        OP_HALT,
        OP_RET,
        OP_CALL,
        OP_BR,
        OP_INC
    } seq_op_e;

    // SP counts 0..depth inclusive, so it needs one more code than the entry count.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic seq_op_e decode_op(input logic halt, input logic ret,
                                          input logic call, input logic br);
        if (halt)      return OP_HALT;
        else if (ret)  return OP_RET;
        else if (call) return OP_CALL;
        else if (br)   return OP_BR;
        else           return OP_INC;
    endfunction

endpackage

// File: rtl/prog_seq_if.sv
// Control/LUT-load request bus from Ctrl into the sequencer, plus its status outputs.
interface prog_seq_if #(
    parameter int PC_W   = 10,
    parameter int JPTR_W = 3
);
    logic              stall;
    logic [JPTR_W-1:0] jptr;
    logic              br;
    logic              br_taken;
    logic              call;
    logic              ret;
    logic              halt;
    logic              lut_we;
    logic [JPTR_W-1:0] lut_addr;
    logic [PC_W-1:0]   lut_data;
    logic [PC_W-1:0]   pc;
    logic              done;
    logic              stack_err;

    modport master (
        output stall, jptr, br, br_taken, call, ret, halt, lut_we, lut_addr, lut_data,
        input  pc, done, stack_err
    );

    modport slave (
        input  stall, jptr, br, br_taken, call, ret, halt, lut_we, lut_addr, lut_data,
        output pc, done, stack_err
    );
endinterface

// File: rtl/seq_ret_stack.sv
// Return-address stack with registered SP; overflow/underflow policy belongs to the caller.
module seq_ret_stack
    import prog_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int SP_W  = sp_width(DEPTH);
    localparam int IDX_W = idx_width(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             do_push, do_pop;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;
    assign wr_idx  = IDX_W'(sp_q);
    assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
    assign top_o   = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (do_push)     sp_d = sp_q + SP_W'(1);
        else if (do_pop) sp_d = sp_q - SP_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) sp_q <= '0;
        else         sp_q <= sp_d;
    end

    // NOTE: storage has no reset; entries above SP are never read, so clearing SP is enough.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, runtime jump LUT, call/return stack, stall and halt/fault FSM.
// Define PROG_SEQ_REL_JUMP_EN for PC-relative LUT targets; default is absolute.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int JPTR_W      = 3,
    parameter int STACK_DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      reset_i,
    prog_seq_if.slave bus
);
    localparam int LUT_N = 2 ** JPTR_W;

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [PC_W-1:0] lut_q [LUT_N];
    logic [PC_W-1:0] lut_rd, target, pc_plus1;
    logic [PC_W-1:0] stk_top;
    logic            stk_full, stk_empty, push, pop;
    seq_op_e         op;

    assign pc_plus1 = pc_q + PC_W'(1);
    // Reading before the write lands gives the old entry on a same-cycle write.
    assign lut_rd   = lut_q[bus.jptr];

`ifdef PROG_SEQ_REL_JUMP_EN
    assign target = pc_q + lut_rd;
`else
    assign target = lut_rd;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
        end else if (bus.lut_we) begin
            lut_q[bus.lut_addr] <= bus.lut_data;
        end
    end

    seq_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_plus1),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        op      = decode_op(bus.halt, bus.ret, bus.call, bus.br);

        if (state_q == RUN && !bus.stall) begin
            case (op)
                OP_HALT: begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end
                OP_RET: begin
                    if (stk_empty) begin
                        state_d = FAULT;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = stk_top;
                        pop  = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (stk_full) begin
                        state_d = FAULT;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = target;
                        push = 1'b1;
                    end
                end
                OP_BR:   pc_d = bus.br_taken ? target : pc_plus1;
                default: pc_d = pc_plus1;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RUN;
            pc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.done      = done_q;
    assign bus.stack_err = err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal pins.
module tb_prog_sequencer;

    localparam int PC_W   = 10;
    localparam int JPTR_W = 3;
    localparam int DEPTH  = 4;
    localparam int MASK   = (1 << PC_W) - 1;

    typedef struct {
        bit rst, stall, br, taken, call, ret, halt, we;
        int jptr, waddr, wdata;
    } stim_t;

    logic clk = 1'b0;
    logic reset_i, s_reset;
    int   tests = 0;
    int   fails = 0;

    // Reference state: 0 run, 1 halted, 2 fault
    int m_pc, m_state, m_done, m_err;
    int m_stack[$];
    int m_lut[8];

    prog_seq_if #(.PC_W(PC_W), .JPTR_W(JPTR_W)) bus ();
    prog_seq_if #(.PC_W(3), .JPTR_W(3)) sbus ();

    prog_sequencer #(.PC_W(PC_W), .JPTR_W(JPTR_W), .STACK_DEPTH(DEPTH)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .bus(bus));

    prog_sequencer #(.PC_W(3), .JPTR_W(3), .STACK_DEPTH(4)) u_small (
        .clk_i(clk), .reset_i(s_reset), .bus(sbus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic int tgt(input int j);
`ifdef PROG_SEQ_REL_JUMP_EN
        int off;
        off = (m_lut[j] >= (1 << (PC_W - 1))) ? m_lut[j] - (1 << PC_W) : m_lut[j];
        return (m_pc + off + (1 << PC_W)) & MASK;
`else
        return m_lut[j];
`endif
    endfunction

    task automatic model_step(input stim_t s);
        int t;
        if (s.rst) begin
            m_pc = 0; m_state = 0; m_done = 0; m_err = 0;
            m_stack.delete();
            foreach (m_lut[i]) m_lut[i] = 0;
            return;
        end
        t = tgt(s.jptr);
        if (m_state == 0 && !s.stall) begin
            if (s.halt) begin
                m_state = 1; m_done = 1;
            end else if (s.ret) begin
                if (m_stack.size() == 0) begin
                    m_state = 2; m_done = 1; m_err = 1;
                end else m_pc = m_stack.pop_back();
            end else if (s.call) begin
                if (m_stack.size() == DEPTH) begin
                    m_state = 2; m_done = 1; m_err = 1;
                end else begin
                    m_stack.push_back((m_pc + 1) & MASK);
                    m_pc = t;
                end
            end else if (s.br && s.taken) m_pc = t;
            else m_pc = (m_pc + 1) & MASK;
        end
        if (s.we) m_lut[s.waddr] = s.wdata;
    endtask

    task automatic compare();
        check("pc", int'(bus.pc), m_pc);
        check("done", int'(bus.done), m_done);
        check("stack_err", int'(bus.stack_err), m_err);
    endtask

    // Called at a negedge: drive, advance model, clock, then compare at next negedge.
    task automatic apply(input stim_t s);
        reset_i      = s.rst;
        bus.stall    = s.stall;
        bus.br       = s.br;
        bus.br_taken = s.taken;
        bus.call     = s.call;
        bus.ret      = s.ret;
        bus.halt     = s.halt;
        bus.lut_we   = s.we;
        bus.jptr     = JPTR_W'(s.jptr);
        bus.lut_addr = JPTR_W'(s.waddr);
        bus.lut_data = PC_W'(s.wdata);
        model_step(s);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    function automatic stim_t wr(input int a, input int d);
        stim_t s;
        s = idle(); s.we = 1; s.waddr = a; s.wdata = d;
        return s;
    endfunction

    function automatic stim_t op(input bit br, input bit taken, input bit call,
                                 input bit ret, input bit halt, input int j);
        stim_t s;
        s = idle(); s.br = br; s.taken = taken; s.call = call; s.ret = ret; s.halt = halt;
        s.jptr = j;
        return s;
    endfunction

    initial begin
        stim_t s;
        reset_i = 1'b1;
        s_reset = 1'b1;
        {bus.stall, bus.br, bus.br_taken, bus.call, bus.ret, bus.halt, bus.lut_we} = '0;
        bus.jptr = '0; bus.lut_addr = '0; bus.lut_data = '0;
        {sbus.stall, sbus.br, sbus.br_taken, sbus.call, sbus.ret, sbus.halt, sbus.lut_we} = '0;
        sbus.jptr = '0; sbus.lut_addr = '0; sbus.lut_data = '0;

        // 3-bit PC wraps 7 -> 0 without raising anything
        @(posedge clk); @(negedge clk);
        s_reset = 1'b0;
        check("small_pc_reset", int'(sbus.pc), 0);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); @(negedge clk);
            check("small_pc_wrap", int'(sbus.pc), i % 8);
        end
        check("small_done", int'(sbus.done), 0);

        s = idle(); s.rst = 1; apply(s);
        check("lit_reset_pc", int'(bus.pc), 0);
        check("lit_reset_done", int'(bus.done), 0);

`ifdef PROG_SEQ_REL_JUMP_EN
        apply(wr(1, 'h3FC));
        apply(wr(0, 'h01E));
        apply(op(1, 1, 0, 0, 0, 0));
        check("lit_rel_fwd", int'(bus.pc), 'h020);
        apply(op(1, 1, 0, 0, 0, 1));
        check("lit_rel_back", int'(bus.pc), 'h01C);
`else
        for (int i = 1; i <= 4; i++) begin
            apply(idle());
            check("lit_inc", int'(bus.pc), i);
        end
        apply(wr(2, 'h040));
        check("lit_inc5", int'(bus.pc), 5);
        apply(op(1, 1, 0, 0, 0, 2));
        check("lit_br_taken", int'(bus.pc), 'h040);
        apply(op(1, 0, 0, 0, 0, 2));
        check("lit_br_not_taken", int'(bus.pc), 'h041);
        apply(wr(3, 'h010));
        apply(op(1, 1, 0, 0, 0, 3));
        check("lit_br_to_10", int'(bus.pc), 'h010);
        apply(op(0, 0, 1, 0, 0, 2));
        check("lit_call", int'(bus.pc), 'h040);
        apply(op(0, 0, 0, 1, 0, 0));
        check("lit_ret", int'(bus.pc), 'h011);

        apply(wr(4, 'h100)); apply(wr(5, 'h200)); apply(wr(6, 'h300));
        apply(op(0, 0, 1, 0, 0, 2)); check("lit_nest1", int'(bus.pc), 'h040);
        apply(op(0, 0, 1, 0, 0, 4)); check("lit_nest2", int'(bus.pc), 'h100);
        apply(op(0, 0, 1, 0, 0, 5)); check("lit_nest3", int'(bus.pc), 'h200);
        apply(op(0, 0, 1, 0, 0, 6)); check("lit_nest4", int'(bus.pc), 'h300);
        apply(op(0, 0, 0, 1, 0, 0)); check("lit_unwind1", int'(bus.pc), 'h201);
        apply(op(0, 0, 0, 1, 0, 0)); check("lit_unwind2", int'(bus.pc), 'h101);
        apply(op(0, 0, 0, 1, 0, 0)); check("lit_unwind3", int'(bus.pc), 'h041);
        apply(op(0, 0, 0, 1, 0, 0)); check("lit_unwind4", int'(bus.pc), 'h015);

        for (int i = 0; i < 4; i++) apply(op(0, 0, 1, 0, 0, 2));
        check("lit_full_no_err", int'(bus.stack_err), 0);
        apply(op(0, 0, 1, 0, 0, 2));
        check("lit_ovf_pc", int'(bus.pc), 'h040);
        check("lit_ovf_err", int'(bus.stack_err), 1);
        check("lit_ovf_done", int'(bus.done), 1);
        apply(idle());
        check("lit_fault_frozen", int'(bus.pc), 'h040);

        s = idle(); s.rst = 1; apply(s);
        apply(op(0, 0, 0, 1, 0, 0));
        check("lit_udf_pc", int'(bus.pc), 0);
        check("lit_udf_err", int'(bus.stack_err), 1);

        s = idle(); s.rst = 1; apply(s);
        s = op(1, 1, 0, 0, 0, 2); s.stall = 1; s.we = 1; s.waddr = 2; s.wdata = 'h055;
        apply(s);
        check("lit_stall1", int'(bus.pc), 0);
        s = op(1, 1, 0, 0, 0, 2); s.stall = 1;
        apply(s); apply(s);
        check("lit_stall3", int'(bus.pc), 0);
        apply(op(1, 1, 0, 0, 0, 2));
        check("lit_stall_release", int'(bus.pc), 'h055);
        s = op(1, 1, 0, 0, 0, 2); s.we = 1; s.waddr = 2; s.wdata = 'h077;
        apply(s);
        check("lit_lut_old_value", int'(bus.pc), 'h055);
        apply(op(1, 1, 0, 0, 0, 2));
        check("lit_lut_new_value", int'(bus.pc), 'h077);

        apply(op(0, 0, 1, 0, 1, 2));
        check("lit_halt_pc", int'(bus.pc), 'h077);
        check("lit_halt_done", int'(bus.done), 1);
        check("lit_halt_err", int'(bus.stack_err), 0);
        apply(op(1, 1, 0, 0, 0, 2));
        check("lit_halted_frozen", int'(bus.pc), 'h077);
        s = idle(); s.rst = 1; apply(s);
        check("lit_rst_halted_done", int'(bus.done), 0);
        apply(op(1, 1, 0, 0, 0, 2));
        check("lit_lut_zeroed", int'(bus.pc), 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.halt  = ($urandom_range(0, 79) == 0);
            s.ret   = ($urandom_range(0, 5) == 0);
            s.call  = ($urandom_range(0, 4) == 0);
            s.br    = ($urandom_range(0, 3) == 0);
            s.taken = 1'($urandom_range(0, 1));
            s.we    = ($urandom_range(0, 3) == 0);
            s.jptr  = $urandom_range(0, 7);
            s.waddr = $urandom_range(0, 7);
            s.wdata = $urandom_range(0, MASK);
            apply(s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
